hex_score_sequencer: RTL and testbench

Display controller for the human-benchmark board's eight seven-segment digits. It captures score and lives updates from the reaction-time and chimp-test games and selects the active game's data via `game_mode`. It converts that game's binary score to BCD with a sequential double-dabble engine and drives HEX0–HEX7 with leading-zero blanking. It sits between the game FSMs and the board HEX pins and is the only writer of those pins.

---
 rtl/hex_pkg.sv | 28 ++
 rtl/seg7_decoder.sv | 30 +++
 rtl/hex_score_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_hex_score_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_pkg.sv
// rtl/hex_pkg.sv - shared types and constants for the HEX score sequencer
package hex_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_COMMIT
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    localparam logic MODE_CHIMP = 1'b0;
    localparam logic MODE_REACT = 1'b1;

    localparam int BCD_DIGITS = 4;

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - BCD digit to active-low gfedcba segment pattern
module seg7_decoder
    import hex_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank wins over the digit; non-BCD codes also show nothing
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/hex_score_sequencer.sv
// rtl/hex_score_sequencer.sv - game score capture, double-dabble BCD conversion and HEX drive
module hex_score_sequencer
    import hex_pkg::*;
#(
    parameter int SCORE_W   = 14,
    parameter int LIVES_W   = 2,
    parameter int MAX_SCORE = 9999
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               game_mode,
    input  logic [SCORE_W-1:0] react_score,
    input  logic               react_valid,
    input  logic [SCORE_W-1:0] chimp_score,
    input  logic [LIVES_W-1:0] chimp_lives,
    input  logic               chimp_valid,
    output logic               busy,
    output logic [6:0]         HEX0,
    output logic [6:0]         HEX1,
    output logic [6:0]         HEX2,
    output logic [6:0]         HEX3,
    output logic [6:0]         HEX4,
    output logic [6:0]         HEX5,
    output logic [6:0]         HEX6,
    output logic [6:0]         HEX7
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int DD_W  = BCD_W + SCORE_W;
    localparam int CNT_W = $clog2(SCORE_W);

    logic [SCORE_W-1:0] react_hold;
    logic [SCORE_W-1:0] chimp_hold;
    logic [LIVES_W-1:0] lives_hold;
    logic               prev_mode;
    logic               pending;
    logic               set_pending;
    logic [SCORE_W-1:0] active_hold;
    logic [SCORE_W-1:0] load_score;

    state_t             state;
    logic [DD_W-1:0]    dd_reg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [LIVES_W-1:0] lives_snap;
    logic               mode_snap;

    logic [BCD_W-1:0]   bcd_disp;
    logic [LIVES_W-1:0] lives_disp;
    logic               mode_disp;

    logic               blank1;
    logic               blank2;
    logic               blank3;
    logic               blank7;

    // One double-dabble step: correct every BCD nibble >= 5, then shift left
    function automatic logic [DD_W-1:0] dabble_step(input logic [DD_W-1:0] v);
        logic [DD_W-1:0] t;
        t = v;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (t[SCORE_W + 4*i +: 4] >= 4'd5)
                t[SCORE_W + 4*i +: 4] = t[SCORE_W + 4*i +: 4] + 4'd3;
        end
        return {t[DD_W-2:0], 1'b0};
    endfunction

    // A conversion is needed on an active-game strobe or any mode change
    always_comb begin
        set_pending = 1'b0;
        if (react_valid && game_mode == MODE_REACT)
            set_pending = 1'b1;
        if (chimp_valid && game_mode == MODE_CHIMP)
            set_pending = 1'b1;
        if (game_mode != prev_mode)
            set_pending = 1'b1;
    end

    // Pick the active game's held score and saturate it to four digits
    always_comb begin
        active_hold = (game_mode == MODE_REACT) ? react_hold : chimp_hold;
        load_score  = (active_hold > SCORE_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : active_hold;
    end

    // Holding registers follow their strobes regardless of the active game
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            react_hold <= '0;
            chimp_hold <= '0;
            lives_hold <= '0;
        end else begin
            if (react_valid)
                react_hold <= react_score;
            if (chimp_valid) begin
                chimp_hold <= chimp_score;
                lives_hold <= chimp_lives;
            end
        end
    end

    // Previous mode seeds from the live input on reset so reset alone is no edge
    always_ff @(posedge CLOCK_50) begin
        prev_mode <= game_mode;
    end

    // A new request wins over the clear in LOAD so no late strobe is lost
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            pending <= 1'b0;
        else if (set_pending)
            pending <= 1'b1;
        else if (state == S_LOAD)
            pending <= 1'b0;
    end

    // Conversion sequencer; display registers change only in COMMIT or reset
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            dd_reg     <= '0;
            bit_cnt    <= '0;
            lives_snap <= '0;
            mode_snap  <= MODE_CHIMP;
            bcd_disp   <= '0;
            lives_disp <= '0;
            mode_disp  <= game_mode;
        end else begin
            case (state)
                S_IDLE: begin
                    busy <= pending;
                    if (pending)
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    busy       <= 1'b1;
                    dd_reg     <= {{BCD_W{1'b0}}, load_score};
                    bit_cnt    <= '0;
                    lives_snap <= lives_hold;
                    mode_snap  <= game_mode;
                    state      <= S_SHIFT;
                end
                S_SHIFT: begin
                    busy    <= 1'b1;
                    dd_reg  <= dabble_step(dd_reg);
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(SCORE_W - 1))
                        state <= S_COMMIT;
                end
                S_COMMIT: begin
                    bcd_disp   <= dd_reg[SCORE_W +: BCD_W];
                    lives_disp <= lives_snap;
                    mode_disp  <= mode_snap;
                    busy       <= pending | set_pending;
                    state      <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Leading-zero blanking cascades down from thousands; units always shown
    always_comb begin
        blank3 = (bcd_disp[15:12] == 4'd0);
        blank2 = blank3 && (bcd_disp[11:8] == 4'd0);
        blank1 = blank2 && (bcd_disp[7:4] == 4'd0);
        blank7 = (mode_disp == MODE_REACT);
    end

    seg7_decoder u_hex0 (.digit(bcd_disp[3:0]),   .blank(1'b0),   .seg(HEX0));
    seg7_decoder u_hex1 (.digit(bcd_disp[7:4]),   .blank(blank1), .seg(HEX1));
    seg7_decoder u_hex2 (.digit(bcd_disp[11:8]),  .blank(blank2), .seg(HEX2));
    seg7_decoder u_hex3 (.digit(bcd_disp[15:12]), .blank(blank3), .seg(HEX3));
    seg7_decoder u_hex4 (.digit(4'd0),            .blank(1'b1),   .seg(HEX4));
    seg7_decoder u_hex5 (.digit(4'd0),            .blank(1'b1),   .seg(HEX5));
    seg7_decoder u_hex6 (.digit(4'd0),            .blank(1'b1),   .seg(HEX6));
    seg7_decoder u_hex7 (.digit(4'(lives_disp)),  .blank(blank7), .seg(HEX7));

endmodule

// File: tb/tb_hex_score_sequencer.sv
// tb/tb_hex_score_sequencer.sv - self-checking bench for hex_score_sequencer
module tb_hex_score_sequencer;

    logic        CLOCK_50;
    logic        reset;
    logic        game_mode;
    logic [13:0] react_score;
    logic        react_valid;
    logic [13:0] chimp_score;
    logic [1:0]  chimp_lives;
    logic        chimp_valid;
    logic        busy;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
    logic [6:0]  hex_act [8];

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    // Behavioural model state (plain integers)
    int m_react = 0, m_chimp = 0, m_lives = 0;
    bit m_pending = 0, m_prev = 0, m_busy = 0;
    int m_age = -1;
    int m_snap_score = 0, m_snap_lives = 0;
    bit m_snap_mode = 0;
    int m_disp_score = 0, m_disp_lives = 0;
    bit m_disp_mode = 0;

    hex_score_sequencer dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .game_mode   (game_mode),
        .react_score (react_score),
        .react_valid (react_valid),
        .chimp_score (chimp_score),
        .chimp_lives (chimp_lives),
        .chimp_valid (chimp_valid),
        .busy        (busy),
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .HEX2        (HEX2),
        .HEX3        (HEX3),
        .HEX4        (HEX4),
        .HEX5        (HEX5),
        .HEX6        (HEX6),
        .HEX7        (HEX7)
    );

    assign hex_act[0] = HEX0;
    assign hex_act[1] = HEX1;
    assign hex_act[2] = HEX2;
    assign hex_act[3] = HEX3;
    assign hex_act[4] = HEX4;
    assign hex_act[5] = HEX5;
    assign hex_act[6] = HEX6;
    assign hex_act[7] = HEX7;

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_hex(input int i);
        int p;
        if (i == 7) return m_disp_mode ? 7'h7F : seg_of(m_disp_lives);
        if (i >= 4) return 7'h7F;
        p = (i == 0) ? 1 : (i == 1) ? 10 : (i == 2) ? 100 : 1000;
        if (i > 0 && m_disp_score < p) return 7'h7F;
        return seg_of((m_disp_score / p) % 10);
    endfunction

    // Timeline model: start one edge after a request, snapshot one edge later, show 16 edges after start
    always @(posedge CLOCK_50) begin
        bit req;
        if (reset) begin
            m_react = 0; m_chimp = 0; m_lives = 0;
            m_pending = 0; m_busy = 0; m_age = -1;
            m_prev = game_mode;
            m_disp_score = 0; m_disp_lives = 0; m_disp_mode = game_mode;
        end else begin
            req = (react_valid && game_mode) || (chimp_valid && !game_mode) || (game_mode != m_prev);
            if (m_age < 0) begin
                if (m_pending) begin
                    m_age = 0;
                    m_busy = 1;
                end
            end else begin
                m_age++;
                if (m_age == 1) begin
                    m_snap_score = game_mode ? m_react : m_chimp;
                    if (m_snap_score > 9999) m_snap_score = 9999;
                    m_snap_lives = m_lives;
                    m_snap_mode  = game_mode;
                    m_pending    = 0;
                end
                if (m_age == 16) begin
                    m_disp_score = m_snap_score;
                    m_disp_lives = m_snap_lives;
                    m_disp_mode  = m_snap_mode;
                    m_age  = -1;
                    m_busy = m_pending || req;
                end
            end
            if (req) m_pending = 1;
            if (react_valid) m_react = react_score;
            if (chimp_valid) begin
                m_chimp = chimp_score;
                m_lives = chimp_lives;
            end
            m_prev = game_mode;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge CLOCK_50) begin
        if (check_en) begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (hex_act[i] !== exp_hex(i)) begin
                    errors++;
                    $display("FAIL model_hex%0d t=%0t got %h want %h", i, $time, hex_act[i], exp_hex(i));
                end
            end
            checks++;
            if (busy !== m_busy) begin
                errors++;
                $display("FAIL model_busy t=%0t got %b want %b", $time, busy, m_busy);
            end
        end
    end

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, got, want);
        end
    endtask

    task automatic pulse_react(input int s);
        react_score = 14'(s);
        react_valid = 1'b1;
        step();
        react_valid = 1'b0;
    endtask

    task automatic pulse_chimp(input int s, input int l);
        chimp_score = 14'(s);
        chimp_lives = 2'(l);
        chimp_valid = 1'b1;
        step();
        chimp_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t got timeout want finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; game_mode = 1'b0;
        react_score = '0; react_valid = 1'b0;
        chimp_score = '0; chimp_lives = '0; chimp_valid = 1'b0;
        step();
        check_en = 1'b1;
        step(2);
        reset = 1'b0;
        step();
        chk("reset_hex0", HEX0, 7'h40);
        chk("reset_hex1", HEX1, 7'h7F);
        chk("reset_hex6", HEX6, 7'h7F);
        chk("reset_hex7", HEX7, 7'h40);
        chk("reset_busy", 7'(busy), 7'h00);

        // switch to reaction mode and let it settle
        game_mode = 1'b1;
        step(20);
        chk("mode1_hex7", HEX7, 7'h7F);

        // 347 latency
        pulse_react(347);
        step();
        chk("r347_busy_n1", 7'(busy), 7'h01);
        step(15);
        chk("r347_hold_hex2", HEX2, 7'h7F);
        chk("r347_busy_n16", 7'(busy), 7'h01);
        step();
        chk("r347_hex2", HEX2, 7'h30);
        chk("r347_hex1", HEX1, 7'h19);
        chk("r347_hex0", HEX0, 7'h78);
        chk("r347_hex3", HEX3, 7'h7F);
        chk("r347_busy_n17", 7'(busy), 7'h00);

        // saturation
        pulse_react(12000);
        step(17);
        chk("sat_hex3", HEX3, 7'h10);
        chk("sat_hex0", HEX0, 7'h10);

        // chimp mode
        game_mode = 1'b0;
        step(20);
        pulse_chimp(5, 2);
        step(17);
        chk("c5_hex0", HEX0, 7'h12);
        chk("c5_hex7", HEX7, 7'h24);
        chk("c5_hex1", HEX1, 7'h7F);
        pulse_react(250);
        chk("inactive_busy_n", 7'(busy), 7'h00);
        step(5);
        chk("inactive_busy_n5", 7'(busy), 7'h00);
        step(15);
        chk("inactive_hex0", HEX0, 7'h12);

        // mode switch shows held reaction score
        game_mode = 1'b1;
        step();
        step(16);
        chk("sw_old_hex7", HEX7, 7'h24);
        step();
        chk("sw_hex2", HEX2, 7'h24);
        chk("sw_hex1", HEX1, 7'h12);
        chk("sw_hex0", HEX0, 7'h40);
        chk("sw_hex7", HEX7, 7'h7F);

        // strobe during a conversion
        pulse_react(111);
        step(4);
        pulse_react(2048);
        step(12);
        chk("b111_hex2", HEX2, 7'h79);
        chk("b111_hex0", HEX0, 7'h79);
        step(16);
        chk("b111_hold_hex3", HEX3, 7'h7F);
        step();
        chk("b2048_hex3", HEX3, 7'h24);
        chk("b2048_hex2", HEX2, 7'h40);
        chk("b2048_hex1", HEX1, 7'h19);
        chk("b2048_hex0", HEX0, 7'h00);

        // same-cycle strobes from both games
        react_score = 14'd42; react_valid = 1'b1;
        chimp_score = 14'd7;  chimp_lives = 2'd1; chimp_valid = 1'b1;
        step();
        react_valid = 1'b0; chimp_valid = 1'b0;
        step(17);
        chk("both_hex1", HEX1, 7'h19);
        chk("both_hex0", HEX0, 7'h24);
        game_mode = 1'b0;
        step();
        step(17);
        chk("both_chimp_hex0", HEX0, 7'h78);
        chk("both_chimp_hex7", HEX7, 7'h79);
        chk("both_chimp_hex1", HEX1, 7'h7F);

        // reset mid-conversion
        game_mode = 1'b1;
        step(20);
        pulse_react(999);
        step(7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_hex0", HEX0, 7'h40);
        chk("rst_mid_hex1", HEX1, 7'h7F);
        chk("rst_mid_hex7", HEX7, 7'h7F);
        chk("rst_mid_busy", 7'(busy), 7'h00);
        step(30);
        chk("rst_after_hex0", HEX0, 7'h40);
        chk("rst_after_hex2", HEX2, 7'h7F);

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
